// File: rtl/dpram_pkg.sv
// Shared types and default geometry for the dual-port RAM with init sequencer.
package dpram_pkg;
  typedef enum logic {INIT, READY} state_e;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 10;
  localparam int DEPTH_DEF = 1024;
  localparam int NUM_PORTS = 2;
endpackage

// File: rtl/dpram_if.sv
// Two-port RAM bus: both access ports plus init/collision status.
interface dpram_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic          wen1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] d_in1;
  logic [DW-1:0] d_out1;
  logic          wen2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] d_in2;
  logic [DW-1:0] d_out2;
  logic          init_busy;
  logic          coll;

  modport master (
    output wen1, addr1, d_in1, wen2, addr2, d_in2,
    input  d_out1, d_out2, init_busy, coll
  );
  modport slave (
    input  wen1, addr1, d_in1, wen2, addr2, d_in2,
    output d_out1, d_out2, init_busy, coll
  );
endinterface

// File: rtl/dpram_init_seq.sv
// Init sequencer: sweeps every word address once after reset, then idles in READY.
module dpram_init_seq
  import dpram_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = ~rst;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  // rst is folded in so busy reads high even before the state flop sees reset
  assign busy      = rst | (state_q == INIT);
  assign init_addr = cnt_q;
endmodule

// File: rtl/dpram_param.sv
// Dual-port RAM, read-first / no-change, with init sweep and write-write collision flag.
// Optional macro DPRAM_OUTREG_EN adds an output register per port (read latency 2).
module dpram_param
  import dpram_pkg::*;
#(
  parameter int          DW       = DW_DEF,
  parameter int          AW       = AW_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic    clk,
  input  logic    rst,
  dpram_if.slave  bus
);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic                                busy, init_we, ready;
  logic [AW-1:0]                       init_addr;
  logic [NUM_PORTS-1:0]                wen, in_rng, we;
  logic [NUM_PORTS-1:0][AW-1:0]        addr;
  logic [NUM_PORTS-1:0][DW-1:0]        din, dout_q, dout_d, dout_o;
  logic                                coll_q, coll_d, same_addr;

  dpram_init_seq #(.AW(AW), .DEPTH(DEPTH)) u_init (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign ready = ~busy;
  assign wen   = {bus.wen2,  bus.wen1};
  assign addr  = {bus.addr2, bus.addr1};
  assign din   = {bus.d_in2, bus.d_in1};

  always_comb begin
    same_addr = (addr[0] == addr[1]);
    coll_d    = ready & wen[0] & wen[1] & same_addr;
    in_rng    = '0;
    we        = '0;
    dout_d    = dout_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_rng[p] = ({1'b0, addr[p]} < DEPTH_X);
      we[p]     = ready & wen[p] & in_rng[p];
      // Reads sample the array before this edge's writes land: read-first
      if (!ready)       dout_d[p] = '0;
      else if (!wen[p]) dout_d[p] = in_rng[p] ? mem[addr[p]] : '0;
    end
    // Port 1 wins a same-address write-write
    if (wen[0] & same_addr) we[1] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
    end else begin
      if (we[0]) mem[addr[0]] <= din[0];
      if (we[1]) mem[addr[1]] <= din[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      coll_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      coll_q <= coll_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [NUM_PORTS-1:0][DW-1:0] oreg_q, oreg_d;

  // Stage 1 already holds on writes, so copying it keeps no-change at the output
  always_comb oreg_d = dout_q;

  always_ff @(posedge clk) begin
    if (rst) oreg_q <= '0;
    else     oreg_q <= oreg_d;
  end

  assign dout_o = oreg_q;
`else
  assign dout_o = dout_q;
`endif

  assign bus.d_out1    = dout_o[0];
  assign bus.d_out2    = dout_o[1];
  assign bus.init_busy = busy;
  assign bus.coll      = coll_q;
endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: a 16-word instance and a 12-word (AW=4) instance.
module tb_dpram_param;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [7:0] IV = 8'h5A;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   na, nb, ncol, nout;

  always #5 clk = ~clk;

  dpram_if #(.DW(8), .AW(4)) a_if ();
  dpram_if #(.DW(8), .AW(4)) b_if ();

  dpram_param #(.DW(8), .AW(4), .DEPTH(16), .INIT_VAL(IV)) u_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );
  dpram_param #(.DW(8), .AW(4), .DEPTH(12), .INIT_VAL(IV)) u_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic rd_a(input logic [3:0] ad, input logic [7:0] e, input string tag);
    a_if.wen1 = 1'b0; a_if.wen2 = 1'b0;
    a_if.addr1 = ad;  a_if.addr2 = ad;
    repeat (LAT) cyc();
    chk({tag, "_p1"}, 16'(a_if.d_out1), 16'(e));
    chk({tag, "_p2"}, 16'(a_if.d_out2), 16'(e));
  endtask

  task automatic rd_b(input logic [3:0] ad, input logic [7:0] e, input string tag);
    b_if.wen1 = 1'b0; b_if.wen2 = 1'b0;
    b_if.addr1 = ad;  b_if.addr2 = ad;
    repeat (LAT) cyc();
    chk({tag, "_p1"}, 16'(b_if.d_out1), 16'(e));
    chk({tag, "_p2"}, 16'(b_if.d_out2), 16'(e));
  endtask

  initial begin
    rst = 1'b1;
    a_if.wen1 = 0; a_if.addr1 = 0; a_if.d_in1 = 0;
    a_if.wen2 = 0; a_if.addr2 = 0; a_if.d_in2 = 0;
    b_if.wen1 = 0; b_if.addr1 = 0; b_if.d_in1 = 0;
    b_if.wen2 = 0; b_if.addr2 = 0; b_if.d_in2 = 0;
    cyc(); cyc();
    chk("rst_busy_a",  16'(a_if.init_busy), 16'd1);
    chk("rst_busy_b",  16'(b_if.init_busy), 16'd1);
    chk("rst_dout1_a", 16'(a_if.d_out1), 16'd0);
    chk("rst_dout2_a", 16'(a_if.d_out2), 16'd0);
    chk("rst_coll_a",  16'(a_if.coll), 16'd0);

    // Release reset while hammering a colliding write that must be dropped
    rst = 1'b0;
    a_if.wen1 = 1; a_if.addr1 = 4'd2; a_if.d_in1 = 8'h77;
    a_if.wen2 = 1; a_if.addr2 = 4'd2; a_if.d_in2 = 8'h66;
    na = 0; nb = 0; ncol = 0; nout = 0;
    for (int i = 0; i < 24; i++) begin
      if (a_if.init_busy) begin
        na++;
        if (a_if.coll) ncol++;
        if (a_if.d_out1 != 8'h00 || a_if.d_out2 != 8'h00) nout++;
      end else begin
        a_if.wen1 = 0; a_if.wen2 = 0;
      end
      if (b_if.init_busy) nb++;
      cyc();
    end
    chk("init_len_16", 16'(na), 16'd16);
    chk("init_len_12", 16'(nb), 16'd12);
    chk("init_coll",   16'(ncol), 16'd0);
    chk("init_dout",   16'(nout), 16'd0);
    chk("ready_busy",  16'(a_if.init_busy), 16'd0);

    for (int i = 0; i < 16; i++) rd_a(4'(i), IV, $sformatf("init_a%0d", i));
    for (int i = 0; i < 12; i++) rd_b(4'(i), IV, $sformatf("init_b%0d", i));

    // Port 1 write, then port 2 read back
    a_if.wen1 = 1; a_if.addr1 = 4'd3; a_if.d_in1 = 8'hA5;
    a_if.wen2 = 0; a_if.addr2 = 4'd0;
    cyc();
    a_if.wen1 = 0; a_if.addr2 = 4'd3;
    repeat (LAT) cyc();
    chk("wr_rd_a5", 16'(a_if.d_out2), 16'h00A5);

    // Write-write collision on addr 7
    a_if.wen1 = 1; a_if.addr1 = 4'd7; a_if.d_in1 = 8'h11;
    a_if.wen2 = 1; a_if.addr2 = 4'd7; a_if.d_in2 = 8'h22;
    cyc();
    chk("coll_pulse", 16'(a_if.coll), 16'd1);
    a_if.wen1 = 0; a_if.wen2 = 0;
    cyc();
    chk("coll_clear", 16'(a_if.coll), 16'd0);
    rd_a(4'd7, 8'h11, "coll_keep_p1");

    // Read-first: port 2 writes 0x33 to addr 5, then port 1 overwrites while port 2 reads
    a_if.wen2 = 1; a_if.addr2 = 4'd5; a_if.d_in2 = 8'h33;
    a_if.wen1 = 0; a_if.addr1 = 4'd9;
    cyc();
    rd_a(4'd9, IV, "pre_rf");
    a_if.wen1 = 1; a_if.addr1 = 4'd5; a_if.d_in1 = 8'h44;
    a_if.wen2 = 0; a_if.addr2 = 4'd5;
    cyc();
    a_if.wen1 = 0; a_if.addr1 = 4'd9;
    if (LAT == 1) begin
      chk("rf_old",  16'(a_if.d_out2), 16'h0033);
      chk("rf_hold", 16'(a_if.d_out1), 16'(IV));
      chk("rf_coll", 16'(a_if.coll), 16'd0);
    end else begin
      chk("rf_coll", 16'(a_if.coll), 16'd0);
      cyc();
      chk("rf_old",  16'(a_if.d_out2), 16'h0033);
      chk("rf_hold", 16'(a_if.d_out1), 16'(IV));
    end
    rd_a(4'd5, 8'h44, "rf_new");

    // Out-of-range write/read on the 12-word instance
    rd_b(4'd0, IV, "oor_pre");
    b_if.wen1 = 1; b_if.addr1 = 4'd13; b_if.d_in1 = 8'hFF;
    b_if.wen2 = 1; b_if.addr2 = 4'd12; b_if.d_in2 = 8'hEE;
    cyc();
    rd_b(4'd13, 8'h00, "oor_13");
    rd_b(4'd12, 8'h00, "oor_12");
    for (int i = 0; i < 12; i++) rd_b(4'(i), IV, $sformatf("oor_keep%0d", i));

    // Reset from READY, then again mid-init at count 8
    rst = 1'b1;
    cyc();
    chk("rerst_busy", 16'(a_if.init_busy), 16'd1);
    chk("rerst_dout", 16'(a_if.d_out2), 16'd0);
    rst = 1'b0;
    repeat (8) cyc();
    chk("mid_busy", 16'(a_if.init_busy), 16'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_busy", 16'(a_if.init_busy), 16'd1);
    rst = 1'b0;
    na = 0;
    for (int i = 0; i < 24; i++) begin
      if (a_if.init_busy) na++;
      cyc();
    end
    chk("restart_len", 16'(na), 16'd16);
    rd_a(4'd3, IV, "reinit3");
    rd_a(4'd5, IV, "reinit5");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
